// File: rtl/radix4_booth_pkg.sv
// Shared widths, Booth digit type and the triplet decoder for the radix-4 multiplier.
package radix4_booth_pkg;

  localparam int unsigned OPW    = 32;       // operand width
  localparam int unsigned PRW    = 64;       // product width
  localparam int unsigned NUM_PP = OPW / 2;  // one partial product per radix-4 digit

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  // Maps the overlapping triplet {b[2i+1], b[2i], b[2i-1]} to a signed digit in -2..+2.
  function automatic booth_digit_e booth_decode(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;  // 000 and 111
    endcase
    return d;
  endfunction

endpackage

// File: rtl/radix4_booth_core.sv
// Combinational 32x32 signed radix-4 Booth multiplier with a 32-bit-signed overflow flag.
module radix4_booth_core
  import radix4_booth_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PRW-1:0] product,
  output logic           overflow
);

  logic [PRW-1:0] a_ext;
  logic [OPW:0]   b_ext;
  logic [PRW-1:0] pp;
  logic [PRW-1:0] acc;
  booth_digit_e   digit;
  logic [PRW-OPW:0] hi;

  // Recode b, select each partial product, and accumulate it at weight 4^i.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    a_ext = {{(PRW-OPW){a[OPW-1]}}, a};
    b_ext = {b, 1'b0};  // implicit b[-1] = 0
    acc   = '0;
    pp    = '0;
    digit = ZERO;
    for (int i = 0; i < NUM_PP; i++) begin
      digit = booth_decode(b_ext[2*i +: 3]);
      case (digit)
        POS1:    pp = a_ext;
        POS2:    pp = a_ext << 1;
        NEG1:    pp = -a_ext;
        NEG2:    pp = -(a_ext << 1);
        default: pp = '0;
      endcase
      acc = acc + (pp << (2*i));  // wraps mod 2^64, which is exact for a 32x32 product
    end
  end

  // The product fits in 32-bit signed only if bits 63..31 are a pure sign extension.
  always_comb begin
    hi       = acc[PRW-1:OPW-1];
    product  = acc;
    overflow = ~((&hi) | ~(|hi));
  end

endmodule

// File: rtl/radix4_booth_with_regs.sv
// Registered radix-4 Booth multiplier: input registers, combinational core, output registers.
// Fixed two-enabled-edge latency, no handshake.
module radix4_booth_with_regs
  import radix4_booth_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PRW-1:0] product,
  output logic           overflow
);

  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  logic [PRW-1:0] core_product;
  logic           core_overflow;

  radix4_booth_core u_core (
    .a        (a_q),
    .b        (b_q),
    .product  (core_product),
    .overflow (core_overflow)
  );

  // Both pipeline stages advance together on enabled edges; reset overrides enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let stage 2 see the old a_q/b_q in the same edge.
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      a_q      <= a;
      b_q      <= b;
      product  <= core_product;
      overflow <= core_overflow;
    end
  end

endmodule

// File: tb/tb_radix4_booth_with_regs.sv
// Directed and random checks for the registered radix-4 Booth multiplier.
module tb_radix4_booth_with_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] product;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  localparam longint MAX32 = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MIN32 = -MAX32 - 1;

  radix4_booth_with_regs dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .a        (a),
    .b        (b),
    .product  (product),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the falling edge for driving and sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
  endtask

  // Hold a pair for two edges and check product and overflow against the integer reference.
  task automatic run_pair(input string tag, input logic [31:0] x, input logic [31:0] y);
    longint p;
    logic   ov;
    p  = longint'($signed(x)) * longint'($signed(y));
    ov = (p > MAX32) || (p < MIN32);
    apply(x, y);
    tick(2);
    check({tag, "_prod"}, product, p);
    check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, ov});
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    a     = '0;
    b     = '0;
    @(negedge clk);

    // Reset state
    tick(2);
    check("reset_prod", product, 64'd0);
    check("reset_ovf", {63'd0, overflow}, 64'd0);

    // X inputs with en low must not reach the registers
    en = 1'b0;
    a  = 'x;
    b  = 'x;
    tick(1);
    reset = 1'b0;
    tick(3);
    check("xhold_prod", product, 64'd0);
    check("xhold_ovf", {63'd0, overflow}, 64'd0);
    en = 1'b1;

    // First transaction
    apply(32'd5, -32'sd7);
    tick(2);
    check("first_prod", product, -64'sd35);
    check("first_ovf", {63'd0, overflow}, 64'd0);

    // Directed sequence
    apply(32'd2, 32'd3);     tick(2); check("seq_2x3", product, 64'd6);
    apply(-32'sd12, -32'sd4); tick(2); check("seq_m12xm4", product, 64'd48);
    apply(-32'sd9, 32'd5);   tick(2); check("seq_m9x5", product, -64'sd45);
    apply(32'd11, 32'd0);    tick(2); check("seq_11x0", product, 64'd0);
    apply(32'd10, 32'd1);    tick(2); check("seq_10x1", product, 64'd10);
    apply(32'd4, 32'd6);     tick(2); check("seq_4x6", product, 64'd24);
    apply(-32'sd1, -32'sd7); tick(2); check("seq_m1xm7", product, 64'd7);
    check("seq_ovf", {63'd0, overflow}, 64'd0);

    // Corners
    apply(32'h7FFF_FFFF, 32'h7FFF_FFFF); tick(2);
    check("max_sq_prod", product, 64'h3FFF_FFFF_0000_0001);
    check("max_sq_ovf", {63'd0, overflow}, 64'd1);
    apply(32'h8000_0000, 32'h8000_0000); tick(2);
    check("min_sq_prod", product, 64'h4000_0000_0000_0000);
    check("min_sq_ovf", {63'd0, overflow}, 64'd1);
    apply(32'h8000_0000, 32'd1); tick(2);
    check("min_x1_prod", product, 64'hFFFF_FFFF_8000_0000);
    check("min_x1_ovf", {63'd0, overflow}, 64'd0);

    // Enable hold
    apply(32'd3, 32'd4); tick(2);
    check("en_load", product, 64'd12);
    en = 1'b0;
    apply(32'd100, 32'd100);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("en_hold", product, 64'd12);
    end
    en = 1'b1;
    tick(1);
    check("en_resume_1st", product, 64'd12);
    tick(1);
    check("en_resume_2nd", product, 64'd10000);

    // Latency: new pair visible on the 2nd edge, not the 1st
    apply(32'd7, 32'd8);
    tick(1);
    check("lat_1st_edge", product, 64'd10000);
    tick(1);
    check("lat_2nd_edge", product, 64'd56);

    // Reset mid-stream
    apply(-32'sd3, 32'h7FFF_FFFF);
    tick(2);
    check("mid_before", product, 64'hFFFF_FFFE_8000_0003);
    check("mid_before_ovf", {63'd0, overflow}, 64'd1);
    reset = 1'b1;
    tick(1);
    check("mid_reset_prod", product, 64'd0);
    check("mid_reset_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b0;

    // Random signed pairs, mixing full-range and small values
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) x = 32'($signed(16'($urandom)));
      if (i % 4 == 2) y = 32'($signed(8'($urandom)));
      run_pair("rand", x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
